// File: rtl/aidan_mcnay_rem_unit_pkg.sv
// Shared state encodings and counter sizing for the remainder unit and its benches.
`ifndef AIDAN_MCNAY_REM_UNIT_PKG_SV
`define AIDAN_MCNAY_REM_UNIT_PKG_SV

package aidan_mcnay_rem_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } rem_state_e;

  localparam int unsigned DefaultNbits    = 16;
  localparam int unsigned DefaultCntWidth = $clog2(DefaultNbits);

  // Step counter width for a given operand width; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned nbits);
    return (nbits > 1) ? $clog2(nbits) : 1;
  endfunction

endpackage

`endif

// File: rtl/aidan_mcnay_rem_step.sv
// One restoring-division step: shift in the next dividend bit, subtract divisor if it fits.
module aidan_mcnay_rem_step #(
  parameter int unsigned nbits = 16
) (
  input  logic [nbits:0]   rem,
  input  logic             dividend_bit,
  input  logic [nbits-1:0] divisor,
  output logic [nbits:0]   rem_next
);

  logic [nbits:0] trial;
  logic           unused_rem_msb;

  // The partial remainder never reaches bit nbits, so it drops out of the shift.
  assign trial          = {rem[nbits-1:0], dividend_bit};
  assign rem_next       = (trial >= {1'b0, divisor}) ? trial - {1'b0, divisor} : trial;
  assign unused_rem_msb = rem[nbits];

endmodule

// File: rtl/aidan_mcnay_rem_unit.sv
// Multi-cycle remainder unit (dividend mod divisor), one restoring step per cycle.
// Define AIDAN_MCNAY_REM_UNIT_EARLY_EXIT_EN to skip CALC when the answer is the dividend.
module aidan_mcnay_rem_unit
  import aidan_mcnay_rem_unit_pkg::*;
#(
  parameter int unsigned nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [nbits-1:0] istream_dividend,
  input  logic [nbits-1:0] istream_divisor,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [nbits-1:0] ostream_remainder
);

  localparam int unsigned CntW = cnt_width(nbits);

  rem_state_e       state_q, state_d;
  logic [nbits:0]   rem_q, rem_d, rem_step;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [nbits-1:0] dividend_q, dividend_d;
  logic [nbits-1:0] divisor_q, divisor_d;

  aidan_mcnay_rem_step #(
    .nbits(nbits)
  ) u_step (
    .rem         (rem_q),
    .dividend_bit(dividend_q[cnt_q]),
    .divisor     (divisor_q),
    .rem_next    (rem_step)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    unique case (state_q)
      StIdle: begin
        if (istream_val) begin
          dividend_d = istream_dividend;
          divisor_d  = istream_divisor;
          rem_d      = '0;
          cnt_d      = CntW'(nbits - 1);
          state_d    = StCalc;
`ifdef AIDAN_MCNAY_REM_UNIT_EARLY_EXIT_EN
          if ((istream_divisor == '0) || (istream_dividend < istream_divisor)) begin
            rem_d   = {1'b0, istream_dividend};
            state_d = StDone;
          end
`endif
        end
      end
      StCalc: begin
        rem_d = rem_step;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (ostream_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
    end
  end

  assign istream_rdy       = (state_q == StIdle);
  assign ostream_val       = (state_q == StDone);
  assign ostream_remainder = ostream_val ? rem_q[nbits-1:0] : '0;

endmodule

// File: tb/tb_aidan_mcnay_rem_unit.sv
// Scoreboard bench for aidan_mcnay_rem_unit: directed corner cases plus a random stream.
module tb_aidan_mcnay_rem_unit;

  localparam int unsigned NBITS   = 16;
  localparam int unsigned TIMEOUT = 400;

  typedef struct {
    logic [NBITS-1:0] rem;
    int unsigned      lat;
    longint           t_acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             istream_val;
  logic             istream_rdy;
  logic [NBITS-1:0] istream_dividend;
  logic [NBITS-1:0] istream_divisor;
  logic             ostream_val;
  logic             ostream_rdy;
  logic [NBITS-1:0] ostream_remainder;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;
  logic prev_val = 1'b0;

  always #5 clk = ~clk;

  aidan_mcnay_rem_unit #(
    .nbits(NBITS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .istream_val      (istream_val),
    .istream_rdy      (istream_rdy),
    .istream_dividend (istream_dividend),
    .istream_divisor  (istream_divisor),
    .ostream_val      (ostream_val),
    .ostream_rdy      (ostream_rdy),
    .ostream_remainder(ostream_remainder)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [NBITS-1:0] ref_rem(input logic [NBITS-1:0] a,
                                               input logic [NBITS-1:0] b);
    int unsigned ai = a;
    int unsigned bi = b;
    if (bi == 0) return a;
    return NBITS'(ai % bi);
  endfunction

  // Cycle number (1 = first cycle after the accept edge) in which ostream_val first rises.
  function automatic int unsigned ref_lat(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
`ifdef AIDAN_MCNAY_REM_UNIT_EARLY_EXIT_EN
    if ((b == 0) || (a < b)) return 1;
`endif
    return NBITS + 1;
  endfunction

  // Monitor: samples on the falling edge, a half cycle away from state changes.
  always @(negedge clk) begin
    if (reset) begin
      prev_val = 1'b0;
    end else begin
      if (ostream_val && !prev_val) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_val: got ostream_val=1 expected no pending request");
        end else begin
          check("latency", int'(($time - sb_q[0].t_acc - 5) / 10) + 1, sb_q[0].lat);
        end
      end
      if (ostream_val && ostream_rdy) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got output handshake expected no pending request");
        end else begin
          mon_e = sb_q.pop_front();
          check("remainder", ostream_remainder, mon_e.rem);
        end
      end
      prev_val = ostream_val;
    end
  end

  // Random consumer back-pressure, enabled only during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      if (rand_rdy) begin
        #1 ostream_rdy = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic send(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
    exp_t e;
    int   n = 0;
    istream_val      = 1'b1;
    istream_dividend = a;
    istream_divisor  = b;
    while (!istream_rdy && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (!istream_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got istream_rdy=0 expected 1 within %0d cycles", TIMEOUT);
      istream_val = 1'b0;
      return;
    end
    @(posedge clk);
    e.rem   = ref_rem(a, b);
    e.lat   = ref_lat(a, b);
    e.t_acc = $time;
    sb_q.push_back(e);
    #1;
    istream_val      = 1'b0;
    istream_dividend = NBITS'($urandom);
    istream_divisor  = NBITS'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    logic [NBITS-1:0] a, b;
    int               n;

    reset            = 1'b1;
    istream_val      = 1'b0;
    istream_dividend = '0;
    istream_divisor  = '0;
    ostream_rdy      = 1'b1;
    #12;
    check("reset_istream_rdy", istream_rdy, 1);
    check("reset_ostream_val", ostream_val, 0);
    check("reset_remainder", ostream_remainder, 0);
    @(negedge clk);
    reset = 1'b0;

    send(16'd97, 16'd7);
    send(16'd91, 16'd13);
    send(16'hFFFF, 16'hFFFE);
    send(16'd5, 16'd0);
    send(16'd5, 16'd9);
    drain();

    // Consumer stall with noisy inputs: output must hold and no new request may enter.
    ostream_rdy = 1'b0;
    send(16'd200, 16'd7);
    n = 0;
    while (!ostream_val && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach_done", ostream_val, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      istream_val      = 1'($urandom);
      istream_dividend = NBITS'($urandom);
      istream_divisor  = NBITS'($urandom);
      @(negedge clk);
      check("stall_val", ostream_val, 1);
      check("stall_remainder", ostream_remainder, 4);
      check("stall_istream_rdy", istream_rdy, 0);
    end
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("post_stall_istream_rdy", istream_rdy, 1);
    check("post_stall_ostream_val", ostream_val, 0);
    check("post_stall_remainder", ostream_remainder, 0);

    // Reset mid-CALC, asserted between clock edges.
    send(16'd1000, 16'd37);
    repeat (8) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_istream_rdy", istream_rdy, 1);
    check("abort_ostream_val", ostream_val, 0);
    check("abort_remainder", ostream_remainder, 0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    send(16'd121, 16'd11);
    drain();

    // Random back-to-back stream with consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = NBITS'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 16'd1;
        2:       b = NBITS'($urandom_range(2, 255));
        3:       b = a;
        4:       b = a + 16'd1;
        default: b = NBITS'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(a, b);
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    ostream_rdy = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
